// File: rtl/soc_clk_rst_seq.sv
// soc_clk_rst_seq: reset sequencer with per-channel clock-enable dividers.
// Releases N_CH channel resets one after another, each DLY+1 cycles apart,
// and generates a divided clock-enable pulse per channel.
// Build option: define SOC_CLK_RST_SEQ_DIV_SHADOW_EN to buffer ratio writes
// in a shadow register that is applied at the channel's next counter wrap.
module soc_clk_rst_seq #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DLY_W   = 8,
  parameter int unsigned DIV_RST = 1,
  parameter int unsigned DLY_RST = 16,
  localparam int unsigned ADDR_W = $clog2(N_CH + 2)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_mode_i,
  input  logic              cfg_req_i,
  input  logic              cfg_wrn_i,
  input  logic [ADDR_W-1:0] cfg_add_i,
  input  logic [31:0]       cfg_data_i,
  output logic              cfg_ack_o,
  output logic [31:0]       cfg_r_data_o,
  output logic [N_CH-1:0]   clk_en_o,
  output logic [N_CH-1:0]   rstn_o,
  output logic              seq_done_o
);

  localparam int unsigned       CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(N_CH);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(N_CH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DLY_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [N_CH-1:0]   rstn_q, rstn_d;
  logic [DLY_W-1:0]  dly_q;

  logic              ack_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd_mux;
  logic              accept, wr_en, rd_en, ctrl_wr, soft_rst, busy;
  logic [N_CH-1:0]   div_wr;
  logic [N_CH-1:0]   wrap;

  logic [DIV_W-1:0]  div_q   [N_CH];
  logic [DIV_W-1:0]  div_cnt [N_CH];
`ifdef SOC_CLK_RST_SEQ_DIV_SHADOW_EN
  logic [DIV_W-1:0]  div_sh_q [N_CH];
`endif

  // Only the ratio, delay and soft-reset fields of the write data are decoded.
  logic unused_data;
  assign unused_data = ^cfg_data_i;

  assign accept   = cfg_req_i & ~ack_q;
  assign wr_en    = accept & ~cfg_wrn_i;
  assign rd_en    = accept & cfg_wrn_i;
  assign ctrl_wr  = wr_en && (cfg_add_i == CTRL_A);
  assign soft_rst = ctrl_wr && cfg_data_i[0];
  assign busy     = (state_q != S_DONE);

  // Per-channel ratio write strobes and wrap detection.
  always_comb begin
    div_wr = '0;
    wrap   = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      div_wr[c] = wr_en && (cfg_add_i == ADDR_W'(c));
      wrap[c]   = (div_q[c] <= DIV_W'(1)) || (div_cnt[c] == div_q[c] - DIV_W'(1));
    end
  end

  // Read data multiplexer.
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cfg_add_i == ADDR_W'(c)) begin
`ifdef SOC_CLK_RST_SEQ_DIV_SHADOW_EN
        rd_mux[DIV_W-1:0] = div_sh_q[c];
`else
        rd_mux[DIV_W-1:0] = div_q[c];
`endif
      end
    end
    if (cfg_add_i == CTRL_A) rd_mux[DLY_W+7:8] = dly_q;
    if (cfg_add_i == STAT_A) rd_mux[1:0] = {seq_done_o, busy};
  end

  // Config handshake: one-cycle ack, read data present only alongside ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= rd_en ? rd_mux : '0;
    end
  end

  // Release delay register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly_q <= DLY_W'(DLY_RST);
    end else if (ctrl_wr) begin
      dly_q <= cfg_data_i[DLY_W+7:8];
    end
  end

  // Ratio registers and divider counters; counters idle at 0 while the channel is held in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        div_q[c]   <= DIV_W'(DIV_RST);
        div_cnt[c] <= '0;
`ifdef SOC_CLK_RST_SEQ_DIV_SHADOW_EN
        div_sh_q[c] <= DIV_W'(DIV_RST);
`endif
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
`ifdef SOC_CLK_RST_SEQ_DIV_SHADOW_EN
        if (div_wr[c]) div_sh_q[c] <= cfg_data_i[DIV_W-1:0];
        // Active ratio only changes at a period boundary (or while idle in reset).
        if (!rstn_q[c] || wrap[c]) div_q[c] <= div_sh_q[c];
        if (!rstn_q[c] || wrap[c]) div_cnt[c] <= '0;
        else                       div_cnt[c] <= div_cnt[c] + DIV_W'(1);
`else
        if (div_wr[c]) div_q[c] <= cfg_data_i[DIV_W-1:0];
        if (!rstn_q[c] || wrap[c] || div_wr[c]) div_cnt[c] <= '0;
        else                                    div_cnt[c] <= div_cnt[c] + DIV_W'(1);
`endif
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      seq_cnt_q <= '0;
      rstn_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      seq_cnt_q <= seq_cnt_d;
      rstn_q    <= rstn_d;
    end
  end

  // Sequencer next state: release one channel each time the count reaches DLY.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    seq_cnt_d = seq_cnt_q;
    rstn_d    = rstn_q;
    case (state_q)
      S_IDLE: state_d = S_COUNT;
      S_COUNT: begin
        if (seq_cnt_q == dly_q) begin
          seq_cnt_d = '0;
          for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch_q == CH_W'(c)) rstn_d[c] = 1'b1;
          end
          if (ch_q == CH_W'(N_CH - 1)) state_d = S_DONE;
          else                         ch_d    = ch_q + CH_W'(1);
        end else begin
          seq_cnt_d = seq_cnt_q + DLY_W'(1);
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (soft_rst) begin
      state_d   = S_IDLE;
      ch_d      = '0;
      seq_cnt_d = '0;
      rstn_d    = '0;
    end
  end

  assign rstn_o       = test_mode_i ? {N_CH{rst_ni}} : rstn_q;
  assign clk_en_o     = test_mode_i ? '1 : (wrap & rstn_q);
  assign seq_done_o   = (state_q == S_DONE);
  assign cfg_ack_o    = ack_q;
  assign cfg_r_data_o = rdata_q;

endmodule

// File: tb/tb_soc_clk_rst_seq.sv
// Directed bench for soc_clk_rst_seq (N_CH=3, DLY 16, DIV 1 at reset).
// Honors SOC_CLK_RST_SEQ_DIV_SHADOW_EN for the ratio-change expectations.
module tb_soc_clk_rst_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        test_mode_i;
  logic        cfg_req_i;
  logic        cfg_wrn_i;
  logic [2:0]  cfg_add_i;
  logic [31:0] cfg_data_i;
  logic        cfg_ack_o;
  logic [31:0] cfg_r_data_o;
  logic [2:0]  clk_en_o;
  logic [2:0]  rstn_o;
  logic        seq_done_o;

  int checks = 0;
  int errors = 0;

  soc_clk_rst_seq #(
    .N_CH(3), .DIV_W(8), .DLY_W(8), .DIV_RST(1), .DLY_RST(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
    .cfg_req_i(cfg_req_i), .cfg_wrn_i(cfg_wrn_i), .cfg_add_i(cfg_add_i),
    .cfg_data_i(cfg_data_i), .cfg_ack_o(cfg_ack_o), .cfg_r_data_o(cfg_r_data_o),
    .clk_en_o(clk_en_o), .rstn_o(rstn_o), .seq_done_o(seq_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        wrn;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue a request now, pass one edge, require ack, return data, drop req.
  task automatic cfg_xact(input logic wrn, input logic [2:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    cfg_req_i  = 1'b1;
    cfg_wrn_i  = wrn;
    cfg_add_i  = addr;
    cfg_data_i = wdata;
    tick();
    check("ack_one_cycle_after_req", 32'(cfg_ack_o), 32'd1);
    rdata     = cfg_r_data_o;
    cfg_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int rel[3];
    int done_at, w, p0, p1, npulse, r0;
    logic [2:0] seq_rstn[5];
    logic       seq_done[5];

    vecs[0]  = '{"rd_status",   1'b1, 3'd4, 32'h0,        32'h2};
    vecs[1]  = '{"rd_unmap5",   1'b1, 3'd5, 32'h0,        32'h0};
    vecs[2]  = '{"rd_unmap7",   1'b1, 3'd7, 32'h0,        32'h0};
    vecs[3]  = '{"rd_div0",     1'b1, 3'd0, 32'h0,        32'h1};
    vecs[4]  = '{"rd_ctrl",     1'b1, 3'd3, 32'h0,        32'h1000};
    vecs[5]  = '{"wr_div0",     1'b0, 3'd0, 32'hFFFFFF05, 32'h0};
    vecs[6]  = '{"rd_div0_new", 1'b1, 3'd0, 32'h0,        32'h5};
    vecs[7]  = '{"wr_unmap6",   1'b0, 3'd6, 32'hFFFF,     32'h0};
    vecs[8]  = '{"rd_unmap6",   1'b1, 3'd6, 32'h0,        32'h0};
    vecs[9]  = '{"wr_status",   1'b0, 3'd4, 32'hFFFFFFFF, 32'h0};
    vecs[10] = '{"rd_status2",  1'b1, 3'd4, 32'h0,        32'h2};
    vecs[11] = '{"wr_div2",     1'b0, 3'd2, 32'h102,      32'h0};
    vecs[12] = '{"rd_div2",     1'b1, 3'd2, 32'h0,        32'h2};
    vecs[13] = '{"rd_div1",     1'b1, 3'd1, 32'h0,        32'h1};

    seq_rstn = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b111};
    seq_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_ni = 1'b0; test_mode_i = 1'b0;
    cfg_req_i = 1'b0; cfg_wrn_i = 1'b0; cfg_add_i = '0; cfg_data_i = '0;
    repeat (3) tick();
    check("reset_rstn",   32'(rstn_o), 32'h0);
    check("reset_clk_en", 32'(clk_en_o), 32'h0);
    check("reset_done",   32'(seq_done_o), 32'h0);
    check("reset_ack",    32'(cfg_ack_o), 32'h0);
    check("reset_rdata",  cfg_r_data_o, 32'h0);

    // Power-on sequence with default delay 16.
    @(negedge clk_i) rst_ni = 1'b1;
    rel = '{-1, -1, -1};
    done_at = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      for (int i = 0; i < 3; i++) if (rel[i] < 0 && rstn_o[i]) rel[i] = cyc;
      if (done_at < 0 && seq_done_o) done_at = cyc;
    end
    check("release_ch0_cycle", 32'(rel[0]), 32'd18);
    check("release_ch1_cycle", 32'(rel[1]), 32'd35);
    check("release_ch2_cycle", 32'(rel[2]), 32'd52);
    check("done_cycle",        32'(done_at), 32'd52);

    // Register map vectors.
    for (int i = 0; i < 14; i++) begin
      cfg_xact(vecs[i].wrn, vecs[i].addr, vecs[i].wdata, rd);
      check({vecs[i].name, "_data"}, rd, vecs[i].exp);
      tick();
      check({vecs[i].name, "_ack_low"}, 32'(cfg_ack_o), 32'h0);
      check({vecs[i].name, "_rdata_idle"}, cfg_r_data_o, 32'h0);
    end

    // DIV[1]=4: one pulse every 4th cycle.
    cfg_xact(1'b0, 3'd1, 32'd4, rd);
    repeat (5) tick();
    npulse = 0; p0 = -1; p1 = -1;
    for (int k = 0; k < 16; k++) begin
      if (clk_en_o[1]) begin
        npulse++;
        if (p0 < 0) p0 = k; else if (p1 < 0) p1 = k;
      end
      tick();
    end
    check("div4_pulse_count", 32'(npulse), 32'd4);
    check("div4_pulse_gap",   32'(p1 - p0), 32'd4);

    // DIV[1]=0: pulse every cycle.
    cfg_xact(1'b0, 3'd1, 32'd0, rd);
    repeat (3) tick();
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      if (clk_en_o[1]) npulse++;
      tick();
    end
    check("div0_pulse_count", 32'(npulse), 32'd8);

    // Ratio change 8 -> 3 three cycles into an 8-cycle period.
    cfg_xact(1'b0, 3'd2, 32'd8, rd);
    repeat (13) tick();
    w = 0;
    while (!clk_en_o[2] && w < 20) begin
      tick();
      w++;
    end
    check("div8_pulse_seen", 32'(clk_en_o[2]), 32'd1);
    repeat (3) tick();
    cfg_xact(1'b0, 3'd2, 32'd3, rd);
    p0 = -1; p1 = -1;
    for (int k = 0; k <= 12; k++) begin
      if (clk_en_o[2]) begin
        if (p0 < 0) p0 = k; else if (p1 < 0) p1 = k;
      end
      if (k < 12) tick();
    end
`ifdef SOC_CLK_RST_SEQ_DIV_SHADOW_EN
    check("ratio_chg_first_pulse",  32'(p0), 32'd4);
    check("ratio_chg_second_pulse", 32'(p1), 32'd7);
`else
    check("ratio_chg_first_pulse",  32'(p0), 32'd2);
    check("ratio_chg_second_pulse", 32'(p1), 32'd5);
`endif

    // Soft reset restart, then a second soft reset while channel 1 is counting.
    cfg_xact(1'b0, 3'd3, 32'h1001, rd);
    check("soft_rst1_rstn", 32'(rstn_o), 32'h0);
    w = 0;
    while (rstn_o != 3'b001 && w < 40) begin
      tick();
      w++;
    end
    check("seq_at_ch1", 32'(rstn_o), 32'h1);
    repeat (5) tick();
    cfg_xact(1'b0, 3'd3, 32'h1001, rd);
    check("soft_rst2_rstn",   32'(rstn_o), 32'h0);
    check("soft_rst2_done",   32'(seq_done_o), 32'h0);
    check("soft_rst2_clk_en", 32'(clk_en_o), 32'h0);
    r0 = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (r0 < 0 && rstn_o[0]) r0 = cyc;
    end
    check("restart_ch0_cycle", 32'(r0), 32'd18);
    check("restart_rstn",      32'(rstn_o), 32'h1);
    cfg_xact(1'b1, 3'd4, 32'h0, rd);
    check("restart_status_busy", rd, 32'h1);
    tick();

    // DLY=0 with soft reset: one channel per cycle.
    cfg_xact(1'b0, 3'd3, 32'h0001, rd);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("dly0_rstn_%0d", k), 32'(rstn_o), 32'(seq_rstn[k]));
      check($sformatf("dly0_done_%0d", k), 32'(seq_done_o), 32'(seq_done[k]));
      tick();
    end
    cfg_xact(1'b1, 3'd3, 32'h0, rd);
    check("rd_ctrl_dly0", rd, 32'h0);
    tick();

    // Test mode: resets follow rst_ni directly, enables forced on.
    test_mode_i = 1'b1;
    #1;
    check("tm_rstn_high",   32'(rstn_o), 32'h7);
    check("tm_clk_en",      32'(clk_en_o), 32'h7);
    #2 rst_ni = 1'b0;
    #1;
    check("tm_rstn_low",    32'(rstn_o), 32'h0);
    check("tm_clk_en_rst",  32'(clk_en_o), 32'h7);
    check("tm_ack_rst",     32'(cfg_ack_o), 32'h0);
    rst_ni = 1'b1;
    #1;
    check("tm_rstn_follow", 32'(rstn_o), 32'h7);
    test_mode_i = 1'b0;
    #1;
    check("post_tm_rstn",   32'(rstn_o), 32'h0);
    check("post_tm_clk_en", 32'(clk_en_o), 32'h0);
    check("post_tm_done",   32'(seq_done_o), 32'h0);

    // Reset asserted mid-transaction: no ack.
    tick();
    cfg_req_i = 1'b1; cfg_wrn_i = 1'b1; cfg_add_i = 3'd4;
    #2 rst_ni = 1'b0;
    tick();
    check("abort_ack",   32'(cfg_ack_o), 32'h0);
    check("abort_rdata", cfg_r_data_o, 32'h0);
    cfg_req_i = 1'b0;
    tick();
    check("abort_ack_hold", 32'(cfg_ack_o), 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    tick();
    cfg_xact(1'b1, 3'd2, 32'h0, rd);
    check("rst_div2_value", rd, 32'h1);
    tick();
    cfg_xact(1'b1, 3'd3, 32'h0, rd);
    check("rst_ctrl_value", rd, 32'h1000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_clk_rst_seq.md
SOC_CLK_RST_SEQ -- requirements
Module: soc_clk_rst_seq

Interface
REQ-001 Parameter N_CH, default 3, number of divided-clock/reset channels (1..8).
REQ-002 Parameter DIV_W, default 8, divider ratio width.
REQ-003 Parameter DLY_W, default 8, reset-release delay width.
REQ-004 Parameter DIV_RST, default 1, reset value of every channel ratio.
REQ-005 Parameter DLY_RST, default 16, reset value of release delay.
REQ-006 One clock, clk_i; reset rst_ni is asynchronous, active-low.
REQ-007 clk_i  in  1  reference clock, sole clock of the block.
REQ-008 rst_ni  in  1  asynchronous active-low global reset.
REQ-009 test_mode_i  in  1  DFT bypass.
REQ-010 cfg_req_i  in  1  config request, held high until ack.
REQ-011 cfg_wrn_i  in  1  0 = write, 1 = read.
REQ-012 cfg_add_i  in  ADDR_W = $clog2(N_CH+2)  register address.
REQ-013 cfg_data_i  in  32  write data.
REQ-014 cfg_ack_o  out  1  one-cycle acknowledge.
REQ-015 cfg_r_data_o  out  32  read data, valid with ack, 0 otherwise.
REQ-016 clk_en_o  out  N_CH  per-channel divided clock-enable pulse.
REQ-017 rstn_o  out  N_CH  per-channel reset, async assert, sync deassert.
REQ-018 seq_done_o  out  1  all channels released.

Function
REQ-019 Register map: addr 0..N_CH-1 DIV[ch] (bits DIV_W-1:0, upper bits ignored); addr N_CH CTRL (bit0 soft reset, write-1 self-clearing; bits DLY_W+7:8 DLY); addr N_CH+1 STATUS read-only (bit0 busy, bit1 done); other addresses read 0, writes ignored.
REQ-020 Handshake: transaction accepted on cycle with cfg_req_i=1 and cfg_ack_o=0; cfg_ack_o=1 exactly the following cycle for one cycle; write takes effect on the same edge ack rises; writes to STATUS or unmapped addresses still acked.
REQ-021 Divider: per-channel counter 0..R-1, R = DIV[ch]; clk_en_o[ch]=1 when counter==R-1; R of 0 or 1 gives clk_en_o[ch]=1 every cycle.
REQ-022 clk_en_o[ch] forced 0 while rstn_o[ch]=0 (outside test mode); counter held at 0.
REQ-023 Sequencer FSM states IDLE, COUNT, DONE; reset enters IDLE, all rstn_o=0, ch=0, cnt=0.
REQ-024 IDLE -> COUNT after one cycle unconditionally.
REQ-025 COUNT: cnt increments each cycle; when cnt==DLY, rstn_o[ch] goes 1 at that edge, cnt<=0, ch<=ch+1; at ch==N_CH-1 go DONE.
REQ-026 DLY compared live; change mid-sequence applies at next compare; DLY=0 releases one channel per cycle.
REQ-027 DONE: seq_done_o=1, busy=0; busy=1 in IDLE and COUNT.
REQ-028 Soft reset write: next edge all rstn_o=0, seq_done_o=0, FSM to IDLE, counters cleared; sequence reruns; soft reset during COUNT restarts from channel 0.
REQ-029 test_mode_i=1: rstn_o = {N_CH{rst_ni}} combinationally, clk_en_o all 1; config interface unaffected.

Reset
REQ-030 During rst_ni=0: cfg_ack_o=0, cfg_r_data_o=0, clk_en_o=0, rstn_o=0, seq_done_o=0, DIV[*]=DIV_RST, DLY=DLY_RST, FSM IDLE.
REQ-031 rst_ni assertion mid-transaction aborts it with no ack; mid-sequence returns all outputs to reset values immediately.

Configuration
REQ-032 Macro SOC_CLK_RST_SEQ_DIV_SHADOW_EN defined: DIV writes go to shadow register, copied to active ratio only when that channel's counter wraps (clk_en_o pulse), giving glitch-free ratio change; read returns shadow.
REQ-033 Macro undefined: DIV write updates active ratio immediately and clears that channel's counter to 0 at the same edge.

Verification
REQ-034 Release rst_ni, DLY=16, N_CH=3 -> rstn_o[0] high 18 cycles after release, [1] +17, [2] +17, seq_done_o then 1.
REQ-035 Write DIV[1]=4 after done -> clk_en_o[1] pulses every 4th cycle; DIV[1]=0 -> every cycle.
REQ-036 Soft reset write during COUNT at ch=1 -> all rstn_o low next cycle, sequence restarts from ch 0, STATUS busy=1.
REQ-037 Read STATUS, unmapped address, DIV[0] -> ack exactly one cycle after req, data 0x2 / 0 / DIV value, 0 when ack low.
REQ-038 test_mode_i=1 with rst_ni toggling -> rstn_o follows rst_ni combinationally, clk_en_o all 1.
REQ-039 With SOC_CLK_RST_SEQ_DIV_SHADOW_EN, DIV 8->3 mid-period -> old period completes, then 3-cycle period; without it, counter restarts, 3-cycle period immediately.
